// File: rtl/fft16_top.sv
// fft16_top: 16-point iterative radix-2 DIT forward FFT, fixed-point, free-running.
// Sequence: LOAD (bit-reversed sample) -> S1..S4 (one butterfly stage per clock) -> OUT.
// Control handshake: there is none. The block samples its inputs on every LOAD edge.
// o_FFT_cycle_done is high for the single cycle in which the state is OUT, and outN_*
// already hold the new results during that cycle.
module fft16_top #(
    parameter int WORD_SIZE = 16,
    parameter int FRACTION  = 8,
    parameter int STAGES    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic signed [WORD_SIZE-1:0] in0_re, in1_re, in2_re, in3_re,
    input  logic signed [WORD_SIZE-1:0] in4_re, in5_re, in6_re, in7_re,
    input  logic signed [WORD_SIZE-1:0] in8_re, in9_re, in10_re, in11_re,
    input  logic signed [WORD_SIZE-1:0] in12_re, in13_re, in14_re, in15_re,
    input  logic signed [WORD_SIZE-1:0] in0_im, in1_im, in2_im, in3_im,
    input  logic signed [WORD_SIZE-1:0] in4_im, in5_im, in6_im, in7_im,
    input  logic signed [WORD_SIZE-1:0] in8_im, in9_im, in10_im, in11_im,
    input  logic signed [WORD_SIZE-1:0] in12_im, in13_im, in14_im, in15_im,
    output logic signed [WORD_SIZE-1:0] out0_re, out1_re, out2_re, out3_re,
    output logic signed [WORD_SIZE-1:0] out4_re, out5_re, out6_re, out7_re,
    output logic signed [WORD_SIZE-1:0] out8_re, out9_re, out10_re, out11_re,
    output logic signed [WORD_SIZE-1:0] out12_re, out13_re, out14_re, out15_re,
    output logic signed [WORD_SIZE-1:0] out0_im, out1_im, out2_im, out3_im,
    output logic signed [WORD_SIZE-1:0] out4_im, out5_im, out6_im, out7_im,
    output logic signed [WORD_SIZE-1:0] out8_im, out9_im, out10_im, out11_im,
    output logic signed [WORD_SIZE-1:0] out12_im, out13_im, out14_im, out15_im,
    output logic                        o_FFT_cycle_done
);

    localparam int N = 1 << STAGES;

    typedef logic signed [WORD_SIZE-1:0] word_t;
    typedef enum logic [2:0] {LOAD, S1, S2, S3, S4, OUT} state_t;

    // Twiddle magnitudes in Q30; rounded down to Q(FRACTION) at elaboration.
    localparam longint C0 = 64'sd1073741824; // 1.0
    localparam longint C1 = 64'sd992008094;  // cos(pi/8)
    localparam longint C2 = 64'sd759250125;  // cos(pi/4)
    localparam longint C3 = 64'sd410903206;  // sin(pi/8)

    state_t state_q, state_d;
    word_t  in_re [N];
    word_t  in_im [N];
    word_t  wr_q [N];
    word_t  wi_q [N];
    word_t  wr_d [N];
    word_t  wi_d [N];
    word_t  out_re_q [N];
    word_t  out_im_q [N];
    word_t  out_re_d [N];
    word_t  out_im_d [N];

    // Round-to-nearest (half away from zero) of a Q30 constant into the word format.
    function automatic word_t q30_to_word(input longint v);
        longint mag;
        longint r;
        mag = (v < 0) ? -v : v;
        r   = (mag + (64'sd1 <<< (29 - FRACTION))) >>> (30 - FRACTION);
        return (v < 0) ? word_t'(-r) : word_t'(r);
    endfunction

    // Real part of W^k = cos(2*pi*k/16).
    function automatic word_t tw_re(input logic [2:0] k);
        case (k)
            3'd0:    return q30_to_word(C0);
            3'd1:    return q30_to_word(C1);
            3'd2:    return q30_to_word(C2);
            3'd3:    return q30_to_word(C3);
            3'd4:    return q30_to_word(64'sd0);
            3'd5:    return q30_to_word(-C3);
            3'd6:    return q30_to_word(-C2);
            default: return q30_to_word(-C1);
        endcase
    endfunction

    // Imaginary part of W^k = -sin(2*pi*k/16).
    function automatic word_t tw_im(input logic [2:0] k);
        case (k)
            3'd0:    return q30_to_word(64'sd0);
            3'd1:    return q30_to_word(-C3);
            3'd2:    return q30_to_word(-C2);
            3'd3:    return q30_to_word(-C1);
            3'd4:    return q30_to_word(-C0);
            3'd5:    return q30_to_word(-C1);
            3'd6:    return q30_to_word(-C2);
            default: return q30_to_word(-C3);
        endcase
    endfunction

    function automatic logic [3:0] bitrev4(input logic [3:0] i);
        return {i[0], i[1], i[2], i[3]};
    endfunction

    assign in_re = '{in0_re, in1_re, in2_re, in3_re, in4_re, in5_re, in6_re, in7_re,
                     in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re};
    assign in_im = '{in0_im, in1_im, in2_im, in3_im, in4_im, in5_im, in6_im, in7_im,
                     in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im};

    assign out0_re  = out_re_q[0];   assign out0_im  = out_im_q[0];
    assign out1_re  = out_re_q[1];   assign out1_im  = out_im_q[1];
    assign out2_re  = out_re_q[2];   assign out2_im  = out_im_q[2];
    assign out3_re  = out_re_q[3];   assign out3_im  = out_im_q[3];
    assign out4_re  = out_re_q[4];   assign out4_im  = out_im_q[4];
    assign out5_re  = out_re_q[5];   assign out5_im  = out_im_q[5];
    assign out6_re  = out_re_q[6];   assign out6_im  = out_im_q[6];
    assign out7_re  = out_re_q[7];   assign out7_im  = out_im_q[7];
    assign out8_re  = out_re_q[8];   assign out8_im  = out_im_q[8];
    assign out9_re  = out_re_q[9];   assign out9_im  = out_im_q[9];
    assign out10_re = out_re_q[10];  assign out10_im = out_im_q[10];
    assign out11_re = out_re_q[11];  assign out11_im = out_im_q[11];
    assign out12_re = out_re_q[12];  assign out12_im = out_im_q[12];
    assign out13_re = out_re_q[13];  assign out13_im = out_im_q[13];
    assign out14_re = out_re_q[14];  assign out14_im = out_im_q[14];
    assign out15_re = out_re_q[15];  assign out15_im = out_im_q[15];

    // Next state: fixed six-step ring, done asserted only while in OUT.
    always_comb begin
        state_d          = state_q;
        o_FFT_cycle_done = 1'b0;
        case (state_q)
            LOAD:    state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S4;
            S4:      state_d = OUT;
            OUT: begin
                state_d          = LOAD;
                o_FFT_cycle_done = 1'b1;
            end
            default: state_d = LOAD;
        endcase
    end

    // Working-register update: bit-reversed load in LOAD, one butterfly stage in S1..S4.
    always_comb begin
        int                           s;
        logic [3:0]                   top;
        logic [3:0]                   bot;
        logic [2:0]                   kk;
        word_t                        wr;
        word_t                        wi;
        word_t                        tr;
        word_t                        ti;
        logic signed [2*WORD_SIZE-1:0] pre;
        logic signed [2*WORD_SIZE-1:0] pim;
        wr_d = wr_q;
        wi_d = wi_q;
        s    = 0;
        top  = '0;
        bot  = '0;
        kk   = '0;
        wr   = '0;
        wi   = '0;
        tr   = '0;
        ti   = '0;
        pre  = '0;
        pim  = '0;
        case (state_q)
            S1:      s = 0;
            S2:      s = 1;
            S3:      s = 2;
            default: s = 3;
        endcase
        if (state_q == LOAD) begin
            for (int i = 0; i < N; i++) begin
                wr_d[i] = in_re[bitrev4(4'(i))];
                wi_d[i] = in_im[bitrev4(4'(i))];
            end
        end else if (state_q != OUT) begin
            // Butterfly b pairs top and top + 2^s; twiddle index is the in-group offset
            // scaled so that the last stage walks W^0..W^7.
            for (int b = 0; b < N / 2; b++) begin
                top = 4'(((b >> s) << (s + 1)) | (b & ((1 << s) - 1)));
                bot = 4'(32'(top) + (1 << s));
                kk  = 3'((b & ((1 << s) - 1)) << (STAGES - 1 - s));
                wr  = tw_re(kk);
                wi  = tw_im(kk);
                pre = wr * wr_q[bot] - wi * wi_q[bot];
                pim = wr * wi_q[bot] + wi * wr_q[bot];
                tr  = word_t'(pre >>> FRACTION);
                ti  = word_t'(pim >>> FRACTION);
                wr_d[top] = wr_q[top] + tr;
                wi_d[top] = wi_q[top] + ti;
                wr_d[bot] = wr_q[top] - tr;
                wi_d[bot] = wi_q[top] - ti;
            end
        end
    end

    // Output capture: the stage-4 result is published on the edge leaving S4.
    always_comb begin
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (state_q == S4) begin
            out_re_d = wr_d;
            out_im_d = wi_d;
        end
    end

    // State, working and output registers with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LOAD;
            for (int i = 0; i < N; i++) begin
                wr_q[i]     <= '0;
                wi_q[i]     <= '0;
                out_re_q[i] <= '0;
                out_im_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            wi_q     <= wi_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

endmodule

// File: tb/tb_fft16_top.sv
// tb_fft16_top: directed checks of fft16_top at default parameters (Q8.8, 16 points).
module tb_fft16_top;

    logic               clk;
    logic               rst;
    logic signed [15:0] x_re [16];
    logic signed [15:0] x_im [16];
    logic signed [15:0] y_re [16];
    logic signed [15:0] y_im [16];
    logic               done;
    int                 tests;
    int                 fails;

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    fft16_top dut (
        .i_clk(clk), .i_rst(rst),
        .in0_re(x_re[0]),   .in1_re(x_re[1]),   .in2_re(x_re[2]),   .in3_re(x_re[3]),
        .in4_re(x_re[4]),   .in5_re(x_re[5]),   .in6_re(x_re[6]),   .in7_re(x_re[7]),
        .in8_re(x_re[8]),   .in9_re(x_re[9]),   .in10_re(x_re[10]), .in11_re(x_re[11]),
        .in12_re(x_re[12]), .in13_re(x_re[13]), .in14_re(x_re[14]), .in15_re(x_re[15]),
        .in0_im(x_im[0]),   .in1_im(x_im[1]),   .in2_im(x_im[2]),   .in3_im(x_im[3]),
        .in4_im(x_im[4]),   .in5_im(x_im[5]),   .in6_im(x_im[6]),   .in7_im(x_im[7]),
        .in8_im(x_im[8]),   .in9_im(x_im[9]),   .in10_im(x_im[10]), .in11_im(x_im[11]),
        .in12_im(x_im[12]), .in13_im(x_im[13]), .in14_im(x_im[14]), .in15_im(x_im[15]),
        .out0_re(y_re[0]),   .out1_re(y_re[1]),   .out2_re(y_re[2]),   .out3_re(y_re[3]),
        .out4_re(y_re[4]),   .out5_re(y_re[5]),   .out6_re(y_re[6]),   .out7_re(y_re[7]),
        .out8_re(y_re[8]),   .out9_re(y_re[9]),   .out10_re(y_re[10]), .out11_re(y_re[11]),
        .out12_re(y_re[12]), .out13_re(y_re[13]), .out14_re(y_re[14]), .out15_re(y_re[15]),
        .out0_im(y_im[0]),   .out1_im(y_im[1]),   .out2_im(y_im[2]),   .out3_im(y_im[3]),
        .out4_im(y_im[4]),   .out5_im(y_im[5]),   .out6_im(y_im[6]),   .out7_im(y_im[7]),
        .out8_im(y_im[8]),   .out9_im(y_im[9]),   .out10_im(y_im[10]), .out11_im(y_im[11]),
        .out12_im(y_im[12]), .out13_im(y_im[13]), .out14_im(y_im[14]), .out15_im(y_im[15]),
        .o_FFT_cycle_done(done)
    );

    // Advance n rising edges, leaving time 1 unit past the last edge for sampling.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_done(input string tag, input int exp);
        check(tag, 32'(done), exp);
    endtask

    task automatic check_bin(input string tag, input int k, input int re, input int im);
        check($sformatf("%s_X%0d_re", tag, k), 32'(y_re[k]), re);
        check($sformatf("%s_X%0d_im", tag, k), 32'(y_im[k]), im);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 16; i++) begin
            x_re[i] = '0;
            x_im[i] = '0;
        end
    endtask

    task automatic set_x(input int n, input int re, input int im);
        x_re[n] = 16'(re);
        x_im[n] = 16'(im);
    endtask

    // Directed sequence
    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        clear_inputs();

        // Reset state
        tick(2);
        check_done("reset_done", 0);
        for (int k = 0; k < 16; k++) check_bin("reset", k, 0, 0);

        // Impulse: first edge with reset low samples, done after the 5th edge
        set_x(0, 256, 0);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check_done($sformatf("imp_done_edge%0d", e), 0);
        end
        tick(1);
        check_done("imp_done_edge5", 1);
        for (int k = 0; k < 16; k++) check_bin("impulse", k, 256, 0);

        // DC, applied while in OUT: only the following LOAD edge takes it
        for (int i = 0; i < 16; i++) set_x(i, 256, 0);
        tick(1);
        check_done("dc_done_low", 0);
        check_bin("hold", 3, 256, 0);
        tick(5);
        check_done("dc_done", 1);
        check_bin("dc", 0, 4096, 0);
        for (int k = 1; k < 16; k++) check_bin("dc", k, 0, 0);

        // Single tone; inputs scrambled right after sampling must not leak in
        clear_inputs();
        set_x(1, 256, 0);
        tick(2);
        for (int i = 0; i < 16; i++) set_x(i, 1000, -500);
        tick(4);
        check_done("tone_done", 1);
        check_bin("tone", 0, 256, 0);
        check_bin("tone", 1, 237, -98);
        check_bin("tone", 2, 181, -181);
        check_bin("tone", 4, 0, -256);
        check_bin("tone", 8, -256, 0);
        check_bin("tone", 9, -237, 98);

        // Mixed: bins on the 0/4/8/12 grid need only exact twiddles
        clear_inputs();
        set_x(0, 362, 201);
        set_x(1, -362, 201);
        set_x(3, 362, -201);
        set_x(7, -362, -201);
        tick(5);
        check_done("mixed_done_low", 0);
        tick(1);
        check_done("mixed_done", 1);
        check_bin("mixed", 0, 0, 0);
        check_bin("mixed", 4, 965, 563);
        check_bin("mixed", 8, 724, 402);
        check_bin("mixed", 12, -241, -161);

        // Reset during S2 aborts the transform
        clear_inputs();
        set_x(0, 256, 0);
        tick(3);
        rst = 1'b1;
        tick(1);
        check_done("abort_done", 0);
        for (int k = 0; k < 16; k++) check_bin("abort", k, 0, 0);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check_done($sformatf("restart_done_edge%0d", e), 0);
        end
        tick(1);
        check_done("restart_done_edge5", 1);
        for (int k = 0; k < 16; k++) check_bin("restart", k, 256, 0);
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            check_done($sformatf("period_low%0d", e), 0);
        end
        tick(1);
        check_done("period_done", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
